// File: rtl/upsp_pkg.sv
// Shared pixel-stream types and default output geometry for the upscaler pipeline.
package upsp_pkg;

    localparam int unsigned DEF_AXIS_DATA_WIDTH = 24;
    localparam int unsigned DEF_DST_IMG_WIDTH   = 3840;
    localparam int unsigned DEF_DST_IMG_HEIGHT  = 2160;

    typedef logic [DEF_AXIS_DATA_WIDTH-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   last;
        logic   user;
    } axis_beat_t;

    // Counter width that stays legal for a degenerate 1-pixel dimension.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_dst_framer_if.sv
// AXI4-Stream pixel channel shared by the framer input and output.
interface axis_dst_framer_if #(
    parameter int unsigned DW = 24
);
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tuser;
    logic          tready;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered ready; full rate with no combinational ready path.
module axis_skid_buffer
    import upsp_pkg::*;
#(
    parameter type T = axis_beat_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_valid_i,
    input  T     s_data_i,
    output logic s_ready_o,
    output logic m_valid_o,
    output T     m_data_o,
    input  logic m_ready_i
);

    logic [1:0] count_q, count_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       ready_q;
    logic       push, pop;

    assign push      = s_valid_i && ready_q;
    assign pop       = (count_q != 2'd0) && m_ready_i;
    assign s_ready_o = ready_q;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = head_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = s_data_i;
                end else begin
                    tail_d = s_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: new beat lands behind whatever becomes head.
                if (count_q == 2'd1) begin
                    head_d = s_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = s_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/axis_dst_framer.sv
// Output framer: regenerates tlast/tuser from geometry counters, checks upstream tlast, flags frame end.
module axis_dst_framer
    import upsp_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter int unsigned DST_IMG_WIDTH   = DEF_DST_IMG_WIDTH,
    parameter int unsigned DST_IMG_HEIGHT  = DEF_DST_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_dst_framer_if.slave   s_axis,
    axis_dst_framer_if.master  m_axis,
    input  logic               err_clr,
    output logic               frame_done,
    output logic               err_early_last,
    output logic               err_miss_last
);

    localparam int unsigned CW = cnt_width(DST_IMG_WIDTH);
    localparam int unsigned RW = cnt_width(DST_IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(DST_IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
        logic                       user;
    } beat_t;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] orow_q, orow_d;
    logic          early_q, early_d;
    logic          miss_q, miss_d;
    logic          done_q, done_d;

    beat_t in_beat, out_beat;
    logic  s_ready, m_valid;
    logic  in_acc, out_acc;
    logic  col_last;
    logic  unused_s_tuser;

    assign unused_s_tuser = s_axis.tuser;

    assign col_last = (col_q == COL_LAST);
    assign in_acc   = s_axis.tvalid && s_ready;
    assign out_acc  = m_valid && m_axis.tready;

    assign in_beat = '{data: s_axis.tdata,
                       last: col_last,
                       user: (col_q == '0) && (row_q == '0)};

    axis_skid_buffer #(
        .T (beat_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_axis.tvalid),
        .s_data_i  (in_beat),
        .s_ready_o (s_ready),
        .m_valid_o (m_valid),
        .m_data_o  (out_beat),
        .m_ready_i (m_axis.tready)
    );

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = out_beat.data;
    assign m_axis.tlast  = out_beat.last;
    assign m_axis.tuser  = out_beat.user;

    assign frame_done     = done_q;
    assign err_early_last = early_q;
    assign err_miss_last  = miss_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        orow_d = orow_q;
        if (in_acc) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
        end
        if (out_acc && out_beat.last) begin
            orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
        end
        // Geometry is authoritative; a bad upstream tlast only raises a flag.
        early_d = (in_acc && s_axis.tlast && !col_last) || (early_q && !err_clr);
        miss_d  = (in_acc && !s_axis.tlast && col_last) || (miss_q && !err_clr);
        done_d  = out_acc && out_beat.last && (orow_q == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            orow_q  <= '0;
            early_q <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            orow_q  <= orow_d;
            early_q <= early_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_axis_dst_framer.sv
// Directed bench for axis_dst_framer on an 8x4 geometry with a scoreboard of expected output beats.
module tb_axis_dst_framer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic frame_done, err_early_last, err_miss_last;

    axis_dst_framer_if #(.DW(DW)) s_if ();
    axis_dst_framer_if #(.DW(DW)) m_if ();

    axis_dst_framer #(
        .AXIS_DATA_WIDTH (DW),
        .DST_IMG_WIDTH   (W),
        .DST_IMG_HEIGHT  (H)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .err_clr        (err_clr),
        .frame_done     (frame_done),
        .err_early_last (err_early_last),
        .err_miss_last  (err_miss_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Sink ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    int mode = 0;
    always @(posedge clk) begin
        #2;
        case (mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b0;
        endcase
    end

    logic [25:0] exp_q[$];
    int ecol = 0, erow = 0, orow = 0, seq = 0;
    int out_cnt = 0, fd_cnt = 0;
    bit mon_en = 0, fd_pend = 0, prev_stall = 0;
    logic [25:0] prev_beat, mon_e;

    function automatic logic [23:0] pix(input int s);
        return 24'((s * 1103) ^ 32'h005A_5A5A);
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            fd_pend    = 0;
            prev_stall = 0;
        end else begin
            check_eq("frame_done", frame_done, fd_pend);
            if (frame_done) fd_cnt++;
            if (prev_stall)
                check_eq("stall_hold", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, {1'b1, prev_beat});
            fd_pend = 0;
            if (m_if.tvalid && m_if.tready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_beat", {m_if.tdata, m_if.tlast, m_if.tuser}, mon_e);
                    if (mon_e[1]) begin
                        fd_pend = (orow == H - 1);
                        orow    = (orow == H - 1) ? 0 : orow + 1;
                    end
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tdata, m_if.tlast, m_if.tuser};
        end
    end

    task automatic send(input logic ul, input logic clr, input int gap);
        bit ok = 0;
        s_if.tvalid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_if.tvalid = 1'b1;
        s_if.tdata  = pix(seq);
        s_if.tlast  = ul;
        err_clr     = clr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_if.tready) begin ok = 1; break; end
        end
        if (ok) begin
            exp_q.push_back({pix(seq), ecol == W - 1, (ecol == 0) && (erow == 0)});
            seq++;
            if (ecol == W - 1) begin
                ecol = 0;
                erow = (erow == H - 1) ? 0 : erow + 1;
            end else begin
                ecol++;
            end
        end else begin
            check_eq("send_accept", ok, 1);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic send_px(input int gap);
        send(ecol == W - 1, 1'b0, gap);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || m_if.tvalid); i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, o0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser,
                                   frame_done, err_early_last, err_miss_last}, '0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
        check_eq("ready_after_reset", s_if.tready, 1);

        // T1: two clean frames at full rate
        t0 = cyc;
        for (int i = 0; i < 2 * W * H; i++) send_px(0);
        check_eq("t1_full_rate", cyc - t0, 2 * W * H);
        drain();
        check_eq("t1_frames_done", fd_cnt, 2);
        check_eq("t1_no_errors", {err_early_last, err_miss_last}, 2'b00);

        // T2: random sink ready and random source gaps
        mode = 1;
        for (int i = 0; i < 2 * W * H; i++) send_px($urandom_range(0, 2));
        mode = 0;
        drain();
        check_eq("t2_frames_done", fd_cnt, 4);
        check_eq("t2_no_errors", {err_early_last, err_miss_last}, 2'b00);

        // T3/T4: early tlast on line 0, missing tlast on lines 2 and 3
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic ul, clr;
                ul  = (c == W - 1);
                clr = 1'b0;
                if (r == 0 && c == 3) ul = 1'b1;
                if (r >= 2 && c == W - 1) ul = 1'b0;
                if (r == 3 && c == W - 1) clr = 1'b1;
                send(ul, clr, 0);
                if (r == 0 && c == 3) begin
                    check_eq("early_set", err_early_last, 1);
                    check_eq("early_no_miss", err_miss_last, 0);
                end
                if (r == 0 && c == W - 1) begin
                    check_eq("early_sticky", err_early_last, 1);
                    pulse_clr();
                    check_eq("early_cleared", err_early_last, 0);
                end
                if (r == 2 && c == W - 1) begin
                    check_eq("miss_set", err_miss_last, 1);
                    pulse_clr();
                    check_eq("miss_cleared", err_miss_last, 0);
                end
                if (r == 3 && c == W - 1) begin
                    check_eq("miss_set_beats_clr", err_miss_last, 1);
                    check_eq("early_stays_clear", err_early_last, 0);
                    pulse_clr();
                end
            end
        end
        drain();
        check_eq("t34_frames_done", fd_cnt, 5);

        // T5: sink stalled, source backs up, then full rate again
        mode = 2;
        send_px(0);
        check_eq("ready_one_buffered", s_if.tready, 1);
        send_px(0);
        check_eq("ready_low_when_full", s_if.tready, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = pix(seq);
        s_if.tlast  = (ecol == W - 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("ready_held_low", s_if.tready, 0);
        end
        @(posedge clk); #1;
        mode = 0;
        send_px(0);
        t0 = cyc;
        o0 = out_cnt;
        repeat (8) send_px(0);
        check_eq("t5_in_rate", cyc - t0, 8);
        check_eq("t5_out_rate", out_cnt - o0, 8);
        drain();

        // T6: asynchronous reset in the middle of line 1 with a full buffer
        for (int i = 0; i < 64; i++) begin
            if (erow == 1 && ecol > 0 && ecol < W - 2) break;
            send_px(0);
        end
        mode = 2;
        send_px(0);
        send_px(0);
        #3;
        mon_en = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("outputs_in_reset", {s_if.tready, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser,
                                          frame_done, err_early_last, err_miss_last}, '0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_q.delete();
        ecol   = 0;
        erow   = 0;
        orow   = 0;
        mode   = 0;
        mon_en = 1;
        @(posedge clk); #1;
        check_eq("ready_after_mid_reset", s_if.tready, 1);
        for (int i = 0; i < W; i++) send_px(0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
